// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: sizes, vector base,
// return-stack entry layout, decision encoding and the vector helper.
package micro_pkg;

    localparam int NUM_IRQ     = 4;
    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int ID_W        = $clog2(NUM_IRQ);

    localparam logic [3:0] VEC_BASE = 4'hF;

    typedef logic [ID_W-1:0] irq_id_t;

    // One saved context: the source being serviced and where to resume.
    typedef struct packed {
        irq_id_t             id;
        logic [ADDR_W-1:0]   pc;
    } ret_entry_t;

    localparam int ENTRY_W = $bits(ret_entry_t);

    // What the controller does with the sequencer in the current cycle.
    typedef enum logic [1:0] {
        DEC_NONE   = 2'd0,
        DEC_TAKE   = 2'd1,
        DEC_RETURN = 2'd2,
        DEC_ERROR  = 2'd3
    } decision_t;

    // Fixed entry point per source: F0 / F4 / F8 / FC.
    function automatic logic [ADDR_W-1:0] vector_addr(input irq_id_t id);
        return {VEC_BASE, id[1:0], 2'b00};
    endfunction

endpackage

// File: rtl/interrupt_controller_ret_stack.sv
// Return-address LIFO. The pointer carries one extra bit so that a full
// stack and an empty stack have distinct encodings. Push and pop are
// never requested together by the controller; push takes precedence if so.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_ptr;

    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_top_idx;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_wr_idx  = r_ptr[IDX_W-1:0];
    assign w_top_idx = w_wr_idx - IDX_W'(1);
    assign empty     = (r_ptr == PTR_W'(0));
    assign full      = (r_ptr == PTR_W'(DEPTH));
    assign count     = r_ptr;
    assign top       = r_mem[w_top_idx];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty && !push;

    // Stack storage: write the new entry at the current pointer on push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= din;
        end else begin
            r_mem[w_wr_idx] <= r_mem[w_wr_idx];
        end
    end

    // Stack pointer: up on push, down on pop, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= PTR_W'(0);
        end else if (w_do_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - PTR_W'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller. At instruction boundaries it either
// redirects the program sequencer to a source's vector (saving the return
// context on a LIFO) or, on rti, forces a jump back to the saved address.
// Nesting is allowed only for strictly higher-priority sources (lower id).
module interrupt_controller
    import micro_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic                 mask_we,
    input  logic [NUM_IRQ-1:0]   mask_wdata,
    input  logic                 fetch_ok,
    input  logic                 rti,
    input  logic [ADDR_W-1:0]    pc_next,
    output logic                 force_jmp,
    output logic [ADDR_W-1:0]    force_addr,
    output logic [NUM_IRQ-1:0]   irq_ack,
    output logic                 in_isr,
    output logic                 stack_err
);

    localparam int PTR_W = $clog2(STACK_DEPTH) + 1;

    logic [NUM_IRQ-1:0]  r_mask;
    logic                r_in_isr;
    logic                r_stack_err;

    logic [NUM_IRQ-1:0]  w_pend;
    irq_id_t             w_win_id;
    logic                w_win_valid;
    logic                w_take_ok;
    decision_t           w_decision;

    ret_entry_t          w_push_entry;
    logic [ENTRY_W-1:0]  w_top_raw;
    ret_entry_t          w_top;
    logic                w_empty;
    logic                w_full;
    logic [PTR_W-1:0]    w_count;
    logic                w_push;
    logic                w_pop;

    assign w_pend = irq & r_mask;
    assign w_top  = ret_entry_t'(w_top_raw);

    // Priority encoder: lowest-numbered pending source wins.
    always_comb begin
        w_win_id    = '0;
        w_win_valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_win_id    = irq_id_t'(i);
                w_win_valid = 1'b1;
            end else begin
                w_win_id    = w_win_id;
                w_win_valid = w_win_valid;
            end
        end
    end

    // A take needs a winner that outranks the level in service and room to save it.
    assign w_take_ok = w_win_valid && !w_full && (w_empty || (w_win_id < w_top.id));

    // Decision: returns beat new requests; nothing happens off a boundary.
    always_comb begin
        w_decision = DEC_NONE;
        if (!fetch_ok) begin
            w_decision = DEC_NONE;
        end else if (rti) begin
            if (w_empty) begin
                w_decision = DEC_ERROR;
            end else begin
                w_decision = DEC_RETURN;
            end
        end else if (w_take_ok) begin
            w_decision = DEC_TAKE;
        end else begin
            w_decision = DEC_NONE;
        end
    end

    // Sequencer redirect, acknowledge and stack control for the decision.
    always_comb begin
        force_jmp  = 1'b0;
        force_addr = '0;
        irq_ack    = '0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        case (w_decision)
            DEC_TAKE: begin
                force_jmp  = 1'b1;
                force_addr = vector_addr(w_win_id);
                irq_ack    = NUM_IRQ'(1) << w_win_id;
                w_push     = 1'b1;
            end
            DEC_RETURN: begin
                force_jmp  = 1'b1;
                force_addr = w_top.pc;
                w_pop      = 1'b1;
            end
            DEC_ERROR: begin
                force_jmp  = 1'b0;
            end
            DEC_NONE: begin
                force_jmp  = 1'b0;
            end
            default: begin
                force_jmp  = 1'b0;
            end
        endcase
    end

    assign w_push_entry = '{id: w_win_id, pc: pc_next};

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ENTRY_W)
    ) u_ret_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_push_entry),
        .top     (w_top_raw),
        .empty   (w_empty),
        .full    (w_full),
        .count   (w_count)
    );

    // Enable mask: new value takes effect from the cycle after the write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end else begin
            r_mask <= r_mask;
        end
    end

    // In-service flag tracks stack occupancy one edge after each push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_isr <= 1'b0;
        end else if (w_push) begin
            r_in_isr <= 1'b1;
        end else if (w_pop) begin
            r_in_isr <= (w_count > PTR_W'(1));
        end else begin
            r_in_isr <= r_in_isr;
        end
    end

    // Sticky error: rti seen at a boundary with nothing to return to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stack_err <= 1'b0;
        end else if (w_decision == DEC_ERROR) begin
            r_stack_err <= 1'b1;
        end else begin
            r_stack_err <= r_stack_err;
        end
    end

    assign in_isr    = r_in_isr;
    assign stack_err = r_stack_err;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench with a cycle-stamped scoreboard. The stimulus
// pushes the expected outputs for each driven cycle; a monitor on the
// falling edge pops and compares, and flags any jump nobody expected.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        fetch_ok;
    logic        rti;
    logic [7:0]  pc_next;
    logic        force_jmp;
    logic [7:0]  force_addr;
    logic [3:0]  irq_ack;
    logic        in_isr;
    logic        stack_err;

    typedef struct {
        int          cyc;
        logic        jmp;
        logic [7:0]  addr;
        logic [3:0]  ack;
        logic        isr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    interrupt_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .fetch_ok   (fetch_ok),
        .rti        (rti),
        .pc_next    (pc_next),
        .force_jmp  (force_jmp),
        .force_addr (force_addr),
        .irq_ack    (irq_ack),
        .in_isr     (in_isr),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare against the expectation stamped for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            cmp("force_jmp", {7'd0, force_jmp}, {7'd0, e.jmp});
            if (e.jmp) cmp("force_addr", force_addr, e.addr);
            cmp("irq_ack", {4'd0, irq_ack}, {4'd0, e.ack});
            cmp("in_isr", {7'd0, in_isr}, {7'd0, e.isr});
            cmp("stack_err", {7'd0, stack_err}, {7'd0, e.err});
        end else begin
            cmp("spurious_jmp", {7'd0, force_jmp}, 8'd0);
        end
    end

    // Drive one cycle of inputs and record what the outputs must be.
    task automatic drv(input logic [3:0] i_irq, input logic i_rti, input logic i_fo,
                       input logic [7:0] i_pc, input logic i_mwe, input logic [3:0] i_md,
                       input logic e_jmp, input logic [7:0] e_addr, input logic [3:0] e_ack,
                       input logic e_isr, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        irq        = i_irq;
        rti        = i_rti;
        fetch_ok   = i_fo;
        pc_next    = i_pc;
        mask_we    = i_mwe;
        mask_wdata = i_md;
        e.cyc  = cyc;
        e.jmp  = e_jmp;
        e.addr = e_addr;
        e.ack  = e_ack;
        e.isr  = e_isr;
        e.err  = e_err;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n    = 1'b0;
        irq        = 4'b0000;
        mask_we    = 1'b0;
        mask_wdata = 4'h0;
        fetch_ok   = 1'b0;
        rti        = 1'b0;
        pc_next    = 8'h00;

        // Reset: everything idle even with requests and a mask write present
        drv(4'b0100, 1'b0, 1'b1, 8'h00, 1'b1, 4'hF, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0100, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Basic take and return
        drv(4'b0000, 1'b0, 1'b1, 8'h10, 1'b1, 4'hF, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0100, 1'b0, 1'b1, 8'h23, 1'b0, 4'h0, 1'b1, 8'hF8, 4'b0100, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'hF9, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hFA, 1'b0, 4'h0, 1'b1, 8'h23, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h24, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Nesting: IRQ3 blocked under IRQ2, IRQ1 preempts, unwind in order
        drv(4'b0100, 1'b0, 1'b1, 8'h40, 1'b0, 4'h0, 1'b1, 8'hF8, 4'b0100, 1'b0, 1'b0);
        drv(4'b1000, 1'b0, 1'b1, 8'hF9, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
        drv(4'b1010, 1'b0, 1'b1, 8'hF9, 1'b0, 4'h0, 1'b1, 8'hF4, 4'b0010, 1'b1, 1'b0);
        drv(4'b1000, 1'b0, 1'b1, 8'hF5, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
        drv(4'b1000, 1'b1, 1'b1, 8'hF6, 1'b0, 4'h0, 1'b1, 8'hF9, 4'b0000, 1'b1, 1'b0);
        drv(4'b1000, 1'b0, 1'b1, 8'hFA, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
        drv(4'b1000, 1'b1, 1'b1, 8'hFB, 1'b0, 4'h0, 1'b1, 8'h40, 4'b0000, 1'b1, 1'b0);
        drv(4'b1000, 1'b0, 1'b1, 8'h41, 1'b0, 4'h0, 1'b1, 8'hFC, 4'b1000, 1'b0, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hFD, 1'b0, 4'h0, 1'b1, 8'h41, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h42, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Mask: IRQ0 disabled, then enabled; taken the cycle after the write
        drv(4'b0000, 1'b0, 1'b1, 8'h42, 1'b1, 4'hE, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0001, 1'b0, 1'b1, 8'h43, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0001, 1'b0, 1'b1, 8'h44, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0001, 1'b0, 1'b1, 8'h45, 1'b1, 4'hF, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0001, 1'b0, 1'b1, 8'h50, 1'b0, 4'h0, 1'b1, 8'hF0, 4'b0001, 1'b0, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hF1, 1'b0, 4'h0, 1'b1, 8'h50, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h51, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

        // No boundary: pending request waits for fetch_ok
        for (int k = 0; k < 3; k++) begin
            drv(4'b0100, 1'b0, 1'b0, 8'h60, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        end
        drv(4'b0100, 1'b0, 1'b1, 8'h60, 1'b0, 4'h0, 1'b1, 8'hF8, 4'b0100, 1'b0, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hF9, 1'b0, 4'h0, 1'b1, 8'h60, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h61, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

        // Fill four levels, further request held, rti beats pending request
        drv(4'b1000, 1'b0, 1'b1, 8'h70, 1'b0, 4'h0, 1'b1, 8'hFC, 4'b1000, 1'b0, 1'b0);
        drv(4'b0100, 1'b0, 1'b1, 8'hFD, 1'b0, 4'h0, 1'b1, 8'hF8, 4'b0100, 1'b1, 1'b0);
        drv(4'b0010, 1'b0, 1'b1, 8'hF9, 1'b0, 4'h0, 1'b1, 8'hF4, 4'b0010, 1'b1, 1'b0);
        drv(4'b0001, 1'b0, 1'b1, 8'hF5, 1'b0, 4'h0, 1'b1, 8'hF0, 4'b0001, 1'b1, 1'b0);
        drv(4'b0001, 1'b0, 1'b1, 8'hF1, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
        drv(4'b0001, 1'b1, 1'b1, 8'hF2, 1'b0, 4'h0, 1'b1, 8'hF5, 4'b0000, 1'b1, 1'b0);
        drv(4'b0001, 1'b0, 1'b1, 8'hF3, 1'b0, 4'h0, 1'b1, 8'hF0, 4'b0001, 1'b1, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hF1, 1'b0, 4'h0, 1'b1, 8'hF3, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hF5, 1'b0, 4'h0, 1'b1, 8'hF9, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hF9, 1'b0, 4'h0, 1'b1, 8'hFD, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'hFD, 1'b0, 4'h0, 1'b1, 8'h70, 4'b0000, 1'b1, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h71, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

        // rti off a boundary is ignored; rti on empty stack sets sticky error
        drv(4'b0000, 1'b1, 1'b0, 8'h72, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h72, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 1'b1, 1'b1, 8'h72, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h73, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);
        drv(4'b0000, 1'b0, 1'b1, 8'h74, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);

        // Reset mid-ISR clears in_isr, error and mask without a clock edge
        drv(4'b0100, 1'b0, 1'b1, 8'h80, 1'b0, 4'h0, 1'b1, 8'hF8, 4'b0100, 1'b0, 1'b1);
        drv(4'b0000, 1'b0, 1'b1, 8'hF9, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b1, 1'b1);
        drv(4'b0100, 1'b0, 1'b1, 8'hFA, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        drv(4'b0100, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        reset_n = 1'b1;
        drv(4'b0100, 1'b0, 1'b1, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b1, 8'h01, 1'b0, 4'h0, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

        @(posedge clk);
        @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
